// File: rtl/return_stack.sv
// Return-address stack feeding the PC parallel-load path: call pushes the PC,
// return pops it onto a registered popData with a one-cycle popValid strobe.
module return_stack #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    input  logic             clrErr,
    output logic [WIDTH-1:0] popData,
    output logic             popValid,
    output logic [WIDTH-1:0] topData,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    // Handshake: push/pop are single-cycle command strobes with no ready;
    // every command is accepted on the edge it is sampled. popValid is a
    // one-cycle qualifier for popData, meant to drive the PC load enable.

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] SP_ONE   = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [PTR_W-1:0] top_idx;
    logic             not_empty;

    assign top_idx   = sp_q - SP_ONE;
    assign not_empty = (count_q != '0);

    always_comb begin
        sp_d        = sp_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        // A new error in the same cycle as clrErr overrides the clear below.
        overflow_d  = overflow_q & ~clrErr;
        underflow_d = underflow_q & ~clrErr;
        mem_we      = 1'b0;
        mem_waddr   = sp_q;

        if (push && pop && not_empty) begin
            // Replace top: return then immediately call again.
            pop_data_d  = mem_q[top_idx];
            pop_valid_d = 1'b1;
            mem_we      = 1'b1;
            mem_waddr   = top_idx;
        end else if (push) begin
            mem_we    = 1'b1;
            mem_waddr = sp_q;
            sp_d      = sp_q + SP_ONE;
            if (count_q == CNT_FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
            if (pop) begin
                underflow_d = 1'b1;
            end
        end else if (pop) begin
            if (not_empty) begin
                pop_data_d  = mem_q[top_idx];
                pop_valid_d = 1'b1;
                sp_d        = top_idx;
                count_d     = count_q - CNT_ONE;
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q        <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[mem_waddr] <= pushData;
        end
    end

    assign popData   = pop_data_q;
    assign popValid  = pop_valid_q;
    assign topData   = not_empty ? mem_q[top_idx] : '0;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: directed scenarios with constant expectations plus
// a randomized run checked against a queue-based stack model.
module tb_return_stack;

    localparam int WIDTH = 13;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             clr_err;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [WIDTH-1:0] top_data;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue whose back is the top of stack.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] m_pop_data;
    logic             m_pop_valid;
    logic             m_overflow;
    logic             m_underflow;

    return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .pushData (push_data),
        .clrErr   (clr_err),
        .popData  (pop_data),
        .popValid (pop_valid),
        .topData  (top_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic model_step(input logic p, input logic q, input logic [WIDTH-1:0] d,
                              input logic c, input logic r);
        int n;
        if (!r) begin
            model_q.delete();
            m_pop_data  = '0;
            m_pop_valid = 1'b0;
            m_overflow  = 1'b0;
            m_underflow = 1'b0;
            return;
        end
        n = model_q.size();
        m_pop_valid = 1'b0;
        if (c) begin
            m_overflow  = 1'b0;
            m_underflow = 1'b0;
        end
        if (p && q && n > 0) begin
            m_pop_data  = model_q[n-1];
            model_q[n-1] = d;
            m_pop_valid = 1'b1;
        end else if (p) begin
            if (q) m_underflow = 1'b1;
            if (n == DEPTH) begin
                void'(model_q.pop_front());
                m_overflow = 1'b1;
            end
            model_q.push_back(d);
        end else if (q) begin
            if (n > 0) begin
                m_pop_data  = model_q.pop_back();
                m_pop_valid = 1'b1;
            end else begin
                m_underflow = 1'b1;
            end
        end
    endtask

    // Drive one clock cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic cycle(input logic p, input logic q, input logic [WIDTH-1:0] d,
                         input logic c, input logic r);
        push = p; pop = q; push_data = d; clr_err = c; rst = r;
        @(posedge clk);
        model_step(p, q, d, c, r);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 13'h0055, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 13'h0066, 1'b0, 1'b0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (pop_data !== 13'h0) begin errors++; $display("FAIL reset_pop_data: got %h expected 0", pop_data); end
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got %b expected 0", pop_valid); end
        checks++; if (top_data !== 13'h0) begin errors++; $display("FAIL reset_top_data: got %h expected 0", top_data); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b unf=%b expected 0 0", overflow, underflow); end
        cycle(1'b0, 1'b0, 13'h0, 1'b0, 1'b1);
    endtask

    task automatic test_basic_lifo();
        logic [WIDTH-1:0] vals [3];
        vals[0] = 13'h0010; vals[1] = 13'h0123; vals[2] = 13'h1FFF;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, vals[i], 1'b0, 1'b1);
            checks++; if (top_data !== vals[i]) begin errors++; $display("FAIL lifo_top: got %h expected %h", top_data, vals[i]); end
        end
        for (int i = 2; i >= 0; i--) begin
            cycle(1'b0, 1'b1, 13'h0, 1'b0, 1'b1);
            checks++; if (pop_data !== vals[i] || pop_valid !== 1'b1) begin errors++; $display("FAIL lifo_pop: got %h/%b expected %h/1", pop_data, pop_valid, vals[i]); end
        end
        cycle(1'b0, 1'b0, 13'h0, 1'b0, 1'b1);
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL lifo_strobe: popValid got %b expected 0", pop_valid); end
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL lifo_end: count=%0d empty=%b expected 0 1", count, empty); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) cycle(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b1);
        checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL ovf_full: full=%b count=%0d expected 1 8", full, count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (top_data !== 13'd9) begin errors++; $display("FAIL ovf_top: got %0d expected 9", top_data); end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 13'h0, 1'b0, 1'b1);
            checks++; if (pop_data !== WIDTH'(9 - i) || pop_valid !== 1'b1) begin errors++; $display("FAIL ovf_pop: got %0d/%b expected %0d/1", pop_data, pop_valid, 9 - i); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", empty); end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b0, 13'h0, 1'b1, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL unf_clr_ovf: got %b expected 0", overflow); end
        cycle(1'b0, 1'b1, 13'h0, 1'b0, 1'b1);
        checks++; if (underflow !== 1'b1 || pop_valid !== 1'b0) begin errors++; $display("FAIL unf_set: unf=%b pv=%b expected 1 0", underflow, pop_valid); end
        checks++; if (pop_data !== 13'd2) begin errors++; $display("FAIL unf_hold: got %0d expected 2", pop_data); end
        cycle(1'b0, 1'b0, 13'h0, 1'b1, 1'b1);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr: got %b expected 0", underflow); end
        cycle(1'b0, 1'b1, 13'h0, 1'b1, 1'b1);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_wins: got %b expected 1", underflow); end
        cycle(1'b0, 1'b0, 13'h0, 1'b1, 1'b1);
    endtask

    task automatic test_push_pop();
        cycle(1'b1, 1'b0, 13'h0AAA, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 13'h0BBB, 1'b0, 1'b1);
        checks++; if (pop_data !== 13'h0AAA || pop_valid !== 1'b1) begin errors++; $display("FAIL pp_pop: got %h/%b expected 0aaa/1", pop_data, pop_valid); end
        checks++; if (count !== 4'd1 || top_data !== 13'h0BBB) begin errors++; $display("FAIL pp_state: count=%0d top=%h expected 1 0bbb", count, top_data); end
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, WIDTH'(13'h100 + i), 1'b0, 1'b1);
        checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL pp_fill: full=%b ovf=%b expected 1 0", full, overflow); end
        cycle(1'b1, 1'b1, 13'h0CCC, 1'b0, 1'b1);
        checks++; if (pop_data !== 13'h0106 || pop_valid !== 1'b1) begin errors++; $display("FAIL pp_full_pop: got %h/%b expected 0106/1", pop_data, pop_valid); end
        checks++; if (overflow !== 1'b0 || count !== 4'd8 || top_data !== 13'h0CCC) begin errors++; $display("FAIL pp_full_state: ovf=%b count=%0d top=%h expected 0 8 0ccc", overflow, count, top_data); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b0, 13'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, WIDTH'(13'h0200 + i), 1'b0, 1'b1);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL mid_pre_count: got %0d expected 5", count); end
        cycle(1'b0, 1'b1, 13'h0, 1'b0, 1'b0);
        checks++; if (count !== 4'd0 || pop_valid !== 1'b0 || pop_data !== 13'h0) begin errors++; $display("FAIL mid_reset: count=%0d pv=%b pd=%h expected 0 0 0", count, pop_valid, pop_data); end
        checks++; if (empty !== 1'b1 || top_data !== 13'h0) begin errors++; $display("FAIL mid_empty: empty=%b top=%h expected 1 0", empty, top_data); end
        cycle(1'b0, 1'b0, 13'h0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic p, q, c, r;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_top;
        int n;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 79) != 0);
            d = WIDTH'($urandom_range(0, 8191));
            cycle(p, q, d, c, r);
            n = model_q.size();
            exp_top = (n > 0) ? model_q[n-1] : '0;
            checks++; if (pop_valid !== m_pop_valid || (m_pop_valid && pop_data !== m_pop_data) || pop_data !== m_pop_data) begin
                errors++; $display("FAIL rand_pop[%0d]: got %h/%b expected %h/%b", i, pop_data, pop_valid, m_pop_data, m_pop_valid);
            end
            checks++; if (count !== (PTR_W+1)'(n) || empty !== (n == 0) || full !== (n == DEPTH)) begin
                errors++; $display("FAIL rand_count[%0d]: got %0d e=%b f=%b expected %0d", i, count, empty, full, n);
            end
            checks++; if (top_data !== exp_top) begin errors++; $display("FAIL rand_top[%0d]: got %h expected %h", i, top_data, exp_top); end
            checks++; if (overflow !== m_overflow || underflow !== m_underflow) begin
                errors++; $display("FAIL rand_flags[%0d]: got ovf=%b unf=%b expected %b %b", i, overflow, underflow, m_overflow, m_underflow);
            end
        end
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0; clr_err = 1'b0;
        model_q.delete();
        m_pop_data = '0; m_pop_valid = 1'b0; m_overflow = 1'b0; m_underflow = 1'b0;
        test_reset();
        test_basic_lifo();
        test_overflow();
        test_underflow();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware return-address stack for the multi-cycle CPU.
- On a call, the controller pushes the current 13-bit PC value (return address) into the stack.
- On a return, the controller pops the stack. The popped address is presented on a registered output together with a one-cycle valid strobe, and is wired to the PC's parallel-load data input and load enable.
- This block is the write-back/source side of the PC load path, where the PC itself is the consumer.

Parameters:
- WIDTH, 13, address width; matches PC width.
- DEPTH, 8, number of stack entries; power of two.
- PTR_W, 3, pointer width; log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- push  input  1  push pushData this cycle.
- pop  input  1  pop the top entry this cycle.
- pushData  input  WIDTH  return address to push (PC value).
- clrErr  input  1  clear sticky error flags.
- popData  output  WIDTH  registered popped address; feeds the PC inData.
- popValid  output  1  one-cycle strobe that popData was updated by a successful pop; feeds the PC loadEn.
- topData  output  WIDTH  combinational view of the current top entry.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a push occurred while full.
- underflow  output  1  sticky: a pop occurred while empty.

Behaviour:
- Storage is a circular array mem[0..DEPTH-1] with write pointer sp, which points to the next free slot. The top entry is mem[sp-1 mod DEPTH].
- Reset (rst==0 at a rising edge) takes priority over every other input, including mid-operation. It sets:
  - sp=0, count=0, popData=0, popValid=0, overflow=0, underflow=0.
  - mem contents need not be cleared.
- Reset outputs: empty=1, full=0, topData=0.
- popValid defaults to 0 every cycle; it is high only in the cycle after a successful pop.
- Push only (push=1, pop=0):
  - mem[sp]<=pushData; sp<=sp+1 (wraps DEPTH-1 to 0).
  - If count<DEPTH, count<=count+1.
  - If count==DEPTH, the oldest entry is overwritten, count stays DEPTH, and overflow<=1.
- Pop only (push=0, pop=1):
  - If count>0: popData<=mem[sp-1]; sp<=sp-1 (wraps 0 to DEPTH-1); count<=count-1; popValid<=1.
  - If count==0: no state change except underflow<=1. popData holds its value and popValid stays 0.
- Push and pop together:
  - If count>0 (replace top): popData<=old mem[sp-1]; mem[sp-1]<=pushData; sp and count unchanged; popValid<=1. No overflow is flagged, even when full.
  - If count==0: performed as a push-only operation; underflow<=1; popValid stays 0.
- Latency:
  - popData and popValid are valid exactly 1 cycle after pop is sampled.
  - A pushed value is visible on topData in the cycle after the push.
- topData = mem[sp-1] when count>0, else 0. Purely combinational from registered state.
- Sticky flags:
  - clrErr=1 clears overflow and underflow.
  - If a new error occurs in the same cycle as clrErr, the new error wins and the flag is set.
- Arithmetic:
  - sp is PTR_W bits and wraps naturally.
  - count is PTR_W+1 bits and saturates at DEPTH; it never wraps.
- empty, full and count reflect the state after the last clock edge.

Test Plan:
- Reset check: hold rst=0 for 2 cycles with push=1 asserted -> count=0, empty=1, popData=0, popValid=0, overflow=0, underflow=0.
- Basic LIFO: push 0x0010, 0x0123, 0x1FFF, then pop 3 times -> popData sequence 0x1FFF, 0x0123, 0x0010, each with a single-cycle popValid; count ends at 0 with empty=1.
- Overflow wrap: push 1..9 (9 pushes, DEPTH=8) -> full=1, count=8, overflow=1. Then pop 8 times -> 9,8,...,2; value 1 is lost.
- Underflow: from empty, pop -> underflow=1, popValid=0, popData unchanged. Then assert clrErr alone -> underflow=0. Then assert pop+clrErr on empty -> underflow=1.
- Simultaneous push+pop: with stack [0x0AAA] (top), push 0x0BBB and pop together -> popData=0x0AAA, popValid=1, count=1, topData=0x0BBB. Repeat when full -> no overflow.
- Reset mid-operation: after pushing 5 entries, pulse rst=0 in the same cycle as pop=1 -> next cycle count=0, popValid=0, popData=0.
